// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes and alu_op encodings shared by decode and EX
package alu_pkg;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_AND = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_SLL = 3'd3;
    localparam logic [2:0] ALU_SRA = 3'd4;
    localparam logic [2:0] ALU_SRL = 3'd5;
    localparam logic [2:0] ALU_SUB = 3'd6;
    localparam logic [2:0] ALU_XOR = 3'd7;

    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_SUB = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;
endpackage

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - ID-side inputs and EX-side outputs of the ID/EX register
interface ex_operand_stage_if #(
    parameter int W   = 32,
    parameter int RAW = 5
);
    logic           stall;
    logic           flush;
    logic           id_valid;
    logic [W-1:0]   rs1_data;
    logic [W-1:0]   rs2_data;
    logic [W-1:0]   imm;
    logic [RAW-1:0] rs1;
    logic [RAW-1:0] rs2;
    logic [RAW-1:0] rd;
    logic [1:0]     alu_op;
    logic [2:0]     funct3;
    logic           funct7_5;
    logic           alu_src;
    logic           reg_write;
    logic           fwd1_we;
    logic [RAW-1:0] fwd1_rd;
    logic [W-1:0]   fwd1_data;
    logic           fwd2_we;
    logic [RAW-1:0] fwd2_rd;
    logic [W-1:0]   fwd2_data;

    logic           ex_valid;
    logic [2:0]     ex_aluctl;
    logic [W-1:0]   ex_a;
    logic [W-1:0]   ex_b;
    logic [W-1:0]   ex_store;
    logic [RAW-1:0] ex_rd;
    logic           ex_regwr;
    logic           ex_illegal;

    modport master (
        output stall, flush, id_valid, rs1_data, rs2_data, imm, rs1, rs2, rd,
               alu_op, funct3, funct7_5, alu_src, reg_write,
               fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data,
        input  ex_valid, ex_aluctl, ex_a, ex_b, ex_store, ex_rd, ex_regwr, ex_illegal
    );

    modport slave (
        input  stall, flush, id_valid, rs1_data, rs2_data, imm, rs1, rs2, rd,
               alu_op, funct3, funct7_5, alu_src, reg_write,
               fwd1_we, fwd1_rd, fwd1_data, fwd2_we, fwd2_rd, fwd2_data,
        output ex_valid, ex_aluctl, ex_a, ex_b, ex_store, ex_rd, ex_regwr, ex_illegal
    );
endinterface

// File: rtl/alu_control.sv
// rtl/alu_control.sv - combinational decode of alu_op/funct3/funct7_5 into the ALU code
module alu_control
    import alu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [2:0] aluctl,
    output logic       illegal
);
    always_comb begin
        aluctl  = ALU_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_ADD: aluctl = ALU_ADD;
            ALUOP_SUB: aluctl = ALU_SUB;
            default: begin
                case (funct3)
                    // I-type has no SUB: bit 30 is part of the immediate there
                    3'b000:  aluctl = (alu_op == ALUOP_R && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b001:  aluctl = ALU_SLL;
                    3'b100:  aluctl = ALU_XOR;
                    3'b101:  aluctl = funct7_5 ? ALU_SRA : ALU_SRL;
                    3'b110:  aluctl = ALU_OR;
                    3'b111:  aluctl = ALU_AND;
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end
endmodule

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX register with operand select; EX_FWD_EN enables result forwarding
module ex_operand_stage
    import alu_pkg::*;
#(
    parameter int W   = 32,
    parameter int RAW = 5
) (
    input  logic               clk,
    input  logic               reset,
    ex_operand_stage_if.slave  bus
);
    logic [2:0]   dec_aluctl;
    logic         dec_illegal;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;

    alu_control u_alu_control (
        .alu_op   (bus.alu_op),
        .funct3   (bus.funct3),
        .funct7_5 (bus.funct7_5),
        .aluctl   (dec_aluctl),
        .illegal  (dec_illegal)
    );

`ifdef EX_FWD_EN
    // x0 is hardwired zero, so a pending write to it must never be forwarded
    function automatic logic [W-1:0] fwd(input logic [RAW-1:0] r, input logic [W-1:0] d);
        if (bus.fwd1_we && bus.fwd1_rd == r && r != '0)
            return bus.fwd1_data;
        else if (bus.fwd2_we && bus.fwd2_rd == r && r != '0)
            return bus.fwd2_data;
        else
            return d;
    endfunction

    assign op_a = fwd(bus.rs1, bus.rs1_data);
    assign op_b = fwd(bus.rs2, bus.rs2_data);
`else
    logic unused_fwd;
    assign unused_fwd = ^{bus.fwd1_we, bus.fwd1_rd, bus.fwd1_data,
                          bus.fwd2_we, bus.fwd2_rd, bus.fwd2_data, bus.rs1, bus.rs2};
    assign op_a = bus.rs1_data;
    assign op_b = bus.rs2_data;
`endif

    logic           valid_q;
    logic [2:0]     aluctl_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [W-1:0]   store_q;
    logic [RAW-1:0] rd_q;
    logic           regwr_q;
    logic           illegal_q;

    always_ff @(posedge clk) begin
        if (reset || bus.flush || (!bus.stall && !bus.id_valid)) begin
            valid_q   <= 1'b0;
            aluctl_q  <= ALU_ADD;
            a_q       <= '0;
            b_q       <= '0;
            store_q   <= '0;
            rd_q      <= '0;
            regwr_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else if (!bus.stall) begin
            valid_q   <= 1'b1;
            aluctl_q  <= dec_aluctl;
            a_q       <= op_a;
            b_q       <= bus.alu_src ? bus.imm : op_b;
            store_q   <= op_b;
            rd_q      <= bus.rd;
            regwr_q   <= bus.reg_write;
            illegal_q <= dec_illegal;
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_aluctl  = aluctl_q;
    assign bus.ex_a       = a_q;
    assign bus.ex_b       = b_q;
    assign bus.ex_store   = store_q;
    assign bus.ex_rd      = rd_q;
    assign bus.ex_regwr   = regwr_q;
    assign bus.ex_illegal = illegal_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - scoreboard bench for ex_operand_stage, directed vectors
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_operand_stage_if #(.W(32), .RAW(5)) ifc ();

    ex_operand_stage #(.W(32), .RAW(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    typedef struct packed {
        logic        valid;
        logic [2:0]  ctl;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [4:0]  rd;
        logic        regwr;
        logic        illegal;
    } exp_t;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_id = 0;

    function automatic exp_t mk(logic v, logic [2:0] c, logic [31:0] a, logic [31:0] b,
                                logic [31:0] s, logic [4:0] rd, logic rw, logic ill);
        exp_t e;
        e = '{valid: v, ctl: c, a: a, b: b, store: s, rd: rd, regwr: rw, illegal: ill};
        return e;
    endfunction

    task automatic set_instr(logic [1:0] op, logic [2:0] f3, logic f75, logic src,
                             logic [4:0] r1, logic [31:0] d1, logic [4:0] r2, logic [31:0] d2,
                             logic [31:0] im, logic [4:0] rd, logic rw);
        ifc.id_valid = 1'b1;
        ifc.alu_op = op; ifc.funct3 = f3; ifc.funct7_5 = f75; ifc.alu_src = src;
        ifc.rs1 = r1; ifc.rs1_data = d1; ifc.rs2 = r2; ifc.rs2_data = d2;
        ifc.imm = im; ifc.rd = rd; ifc.reg_write = rw;
    endtask

    task automatic set_fwd(logic w1, logic [4:0] r1, logic [31:0] d1,
                           logic w2, logic [4:0] r2, logic [31:0] d2);
        ifc.fwd1_we = w1; ifc.fwd1_rd = r1; ifc.fwd1_data = d1;
        ifc.fwd2_we = w2; ifc.fwd2_rd = r2; ifc.fwd2_data = d2;
    endtask

    task automatic apply(exp_t e);
        sb.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: every edge the stage presents a full output word; check it against the queue.
    initial begin
        exp_t e;
        exp_t got;
        int   n = 0;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = mk(ifc.ex_valid, ifc.ex_aluctl, ifc.ex_a, ifc.ex_b, ifc.ex_store,
                         ifc.ex_rd, ifc.ex_regwr, ifc.ex_illegal);
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL vec%0d got v=%b ctl=%0d a=%h b=%h st=%h rd=%0d rw=%b ill=%b want v=%b ctl=%0d a=%h b=%h st=%h rd=%0d rw=%b ill=%b",
                             n, got.valid, got.ctl, got.a, got.b, got.store, got.rd, got.regwr, got.illegal,
                             e.valid, e.ctl, e.a, e.b, e.store, e.rd, e.regwr, e.illegal);
                end
                n++;
            end
        end
    end

    initial begin
        exp_t z;
        exp_t x;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset with garbage inputs, including stall held high
        reset = 1'b1;
        ifc.stall = 1'b1; ifc.flush = 1'b0;
        set_instr(2'b10, 3'b101, 1'b1, 1'b1, 5'd7, 32'hDEADBEEF, 5'd8, 32'hCAFEF00D,
                  32'h12345678, 5'd31, 1'b1);
        set_fwd(1'b1, 5'd7, 32'h1111_1111, 1'b1, 5'd8, 32'h2222_2222);
        apply(z);
        apply(z);

        reset = 1'b0; ifc.stall = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0);

        // R-type SUB
        set_instr(2'b10, 3'b000, 1'b1, 1'b0, 5'd1, 32'd9, 5'd2, 32'd4, 32'd0, 5'd3, 1'b1);
        apply(mk(1, 6, 9, 4, 4, 3, 1, 0));
        // I-type SRAI with immediate
        set_instr(2'b11, 3'b101, 1'b1, 1'b1, 5'd1, 32'd9, 5'd2, 32'd4, 32'd3, 5'd4, 1'b1);
        apply(mk(1, 4, 9, 3, 4, 4, 1, 0));
        // I-type ADDI ignores bit 30
        set_instr(2'b11, 3'b000, 1'b1, 1'b1, 5'd1, 32'd9, 5'd2, 32'd4, 32'd3, 5'd4, 1'b1);
        apply(mk(1, 0, 9, 3, 4, 4, 1, 0));

        // Forwarding: fwd1 beats fwd2
        set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd5, 32'hBB);
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 5'd5, 32'h11, 5'd6, 32'h22, 32'd0, 5'd10, 1'b1);
        apply(mk(1, 0, FWD ? 32'hAA : 32'h11, 32'h22, 32'h22, 10, 1, 0));
        // rs1 = x0 never forwarded
        set_fwd(1'b1, 5'd0, 32'hAA, 1'b1, 5'd0, 32'hBB);
        set_instr(2'b00, 3'b000, 1'b0, 1'b0, 5'd0, 32'h11, 5'd6, 32'h22, 32'd0, 5'd10, 1'b1);
        apply(mk(1, 0, 32'h11, 32'h22, 32'h22, 10, 1, 0));
        // fwd2 only matches rs2; store data also forwarded, ALU B still takes imm
        set_fwd(1'b1, 5'd7, 32'hAA, 1'b1, 5'd6, 32'hBB);
        set_instr(2'b01, 3'b000, 1'b0, 1'b1, 5'd5, 32'h11, 5'd6, 32'h22, 32'h40, 5'd11, 1'b0);
        apply(mk(1, 6, 32'h11, 32'h40, FWD ? 32'hBB : 32'h22, 11, 0, 0));
        set_fwd(0, 0, 0, 0, 0, 0);

        // Load AND, then hold through 3 stall cycles with changing inputs
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 32'd1, 5'd2, 32'd2, 32'd0, 5'd9, 1'b1);
        x = mk(1, 1, 1, 2, 2, 9, 1, 0);
        apply(x);
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_instr(2'b10, 3'b100, 1'b0, 1'b1, 5'd3, 32'h55 + i, 5'd4, 32'h66, 32'h77, 5'd12, 1'b1);
            apply(x);
        end
        ifc.flush = 1'b1;
        apply(z);
        ifc.stall = 1'b0; ifc.flush = 1'b0;

        // Unsupported funct3 is still a valid slot
        set_instr(2'b10, 3'b010, 1'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 5'd13, 1'b1);
        apply(mk(1, 0, 5, 6, 6, 13, 1, 1));
        set_instr(2'b10, 3'b111, 1'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 5'd13, 1'b1);
        apply(mk(1, 1, 5, 6, 6, 13, 1, 0));

        // id_valid=0 loads a bubble
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 32'd5, 5'd2, 32'd6, 32'd0, 5'd13, 1'b1);
        ifc.id_valid = 1'b0;
        apply(z);

        // Remaining R-type codes
        set_instr(2'b10, 3'b101, 1'b0, 1'b0, 5'd1, 32'h80, 5'd2, 32'd1, 32'd0, 5'd14, 1'b0);
        apply(mk(1, 5, 32'h80, 1, 1, 14, 0, 0));
        set_instr(2'b10, 3'b100, 1'b0, 1'b0, 5'd1, 32'hF0, 5'd2, 32'h0F, 32'd0, 5'd15, 1'b1);
        apply(mk(1, 7, 32'hF0, 32'h0F, 32'h0F, 15, 1, 0));
        set_instr(2'b10, 3'b001, 1'b1, 1'b0, 5'd1, 32'h1, 5'd2, 32'h4, 32'd0, 5'd16, 1'b1);
        apply(mk(1, 3, 1, 4, 4, 16, 1, 0));
        set_instr(2'b10, 3'b110, 1'b0, 1'b0, 5'd1, 32'hFFFF_0000, 5'd2, 32'h0000_FFFF, 32'd0, 5'd17, 1'b1);
        apply(mk(1, 2, 32'hFFFF_0000, 32'h0000_FFFF, 32'h0000_FFFF, 17, 1, 0));
        // I-type illegal funct3
        set_instr(2'b11, 3'b011, 1'b1, 1'b1, 5'd1, 32'h3, 5'd2, 32'h4, 32'hFFFF_FFFF, 5'd18, 1'b1);
        apply(mk(1, 0, 3, 32'hFFFF_FFFF, 4, 18, 1, 1));
        // Flush alone with a real instruction present
        ifc.flush = 1'b1;
        set_instr(2'b10, 3'b000, 1'b0, 1'b0, 5'd1, 32'h3, 5'd2, 32'h4, 32'h0, 5'd19, 1'b1);
        apply(z);
        ifc.flush = 1'b0;

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d vectors left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end
endmodule
